// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin sharing of one HD44780 controller among several command sources,
// with a post-completion settle delay before the source is acknowledged.
module lcd_cmd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DLY_CYCLES = 262143,
    parameter int DLY_W      = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [9*NUM_REQ-1:0]   cmd,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic                   c_start,
    output logic [7:0]             c_data,
    output logic                   c_rs,
    input  logic                   c_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DLY   = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;
    logic [2:0]       state;
    logic [8:0]       cmd_q;
    logic [DLY_W-1:0] cnt;
    logic [IW-1:0]    last, gidx, win;
    // Descending scan so the nearest requester after last overwrites farther ones.
    always_comb begin
        win = last;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last) + k) % NUM_REQ]) win = IW'((int'(last) + k) % NUM_REQ);
    end
    assign c_start = state == START;
    assign busy    = state != IDLE;
    assign ack     = (state == ACK) ? grant : '0;
    assign c_data  = cmd_q[7:0];
    assign c_rs    = cmd_q[8];
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            cmd_q <= '0;
            cnt   <= '0;
            last  <= IW'(NUM_REQ - 1);
            gidx  <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    cmd_q <= cmd[9*win +: 9];
                    grant <= NUM_REQ'(1) << win;
                    gidx  <= win;
                    state <= START;
                end
                START: state <= WAIT;
                WAIT: if (c_done) begin
                    cnt   <= '0;
                    state <= DLY;
                end
                DLY: begin
                    cnt <= cnt + DLY_W'(1);
                    if (cnt == DLY_W'(DLY_CYCLES - 1)) state <= ACK;
                end
                ACK: begin
                    last  <= gidx;
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Round-robin arbiter that shares the single HD44780 character-LCD controller (`LCD_Controller_MIPS`) between several command sources, such as the init/refresh sequencer and the MIPS display writer. Each source posts one 9-bit `{RS, DATA[7:0]}` command at a time. The arbiter latches the granted command, pulses the controller start, waits for the controller done, and then enforces the post-command settle delay. Only after that delay does it acknowledge the source. The block sits between the command sources and the controller instance; no other block drives the controller inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `DLY_CYCLES`, 262143: settle cycles after `c_done` before acknowledge (≥1).
- `DLY_W`, 18: width of the settle counter; must hold `DLY_CYCLES-1`.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in NUM_REQ: level request per source; held until its `ack`.
- `cmd` in 9*NUM_REQ: source i command at `[9i+8:9i]`; bit 8 is RS, bits 7:0 are DATA.
- `grant` out NUM_REQ: one-hot, the source currently being served; 0 when idle.
- `ack` out NUM_REQ: one-cycle pulse to the served source when its command has completed.
- `busy` out 1: high in every state except IDLE.
- `c_start` out 1: one-cycle start pulse to the controller.
- `c_data` out 8: DATA to the controller.
- `c_rs` out 1: RS to the controller.
- `c_done` in 1: completion pulse from the controller.

## Operation
- FSM states: IDLE, START, WAIT, DLY, ACK.
- IDLE:
  - If any `req` bit is set, select the winner by round robin.
  - Latch the winner's `cmd` into the command register, register one-hot `grant`, then go to START.
  - If no `req` bit is set, stay in IDLE.
- Round robin:
  - Search starts at index `last+1` and wraps modulo NUM_REQ.
  - `last` updates only in ACK.
  - After reset, `last=NUM_REQ-1`, so source 0 has first priority.
- START: `c_start=1` for exactly this cycle; then go to WAIT.
- WAIT:
  - Hold until `c_done=1`; then clear the settle counter and go to DLY.
  - There is no timeout; the controller always completes.
- DLY:
  - The counter increments each cycle.
  - When the counter equals `DLY_CYCLES-1`, go to ACK. DLY therefore lasts exactly DLY_CYCLES cycles.
- ACK:
  - `ack[g]=1` for the granted source g.
  - `last<=g`; `grant` clears at the end of the cycle; then go to IDLE.
- Command latching:
  - `c_data`/`c_rs` come from the latched command register, not from `cmd` directly.
  - They are stable from START through ACK, and hold their last value in IDLE.
- `c_start` and `ack` are Moore decodes of state. `busy = (state != IDLE)`.
- Boundary conditions:
  - Requester drops `req` after grant: the command still completes and `ack` still pulses.
  - Changes to `cmd` after grant have no effect.
  - `c_done` outside WAIT is ignored.
  - `c_done` in the same cycle as START is ignored; it is only sampled in WAIT.
  - A `req` present during START..ACK waits; it is evaluated only in IDLE.
  - A source whose `ack` is pulsing this cycle may keep `req` high. It is then re-served only after all other pending sources, per round robin.
  - All `req` bits set: service order is 0,1,…,NUM_REQ-1,0,…
- Reset (`rst=0` at a rising edge):
  - State goes to IDLE; `grant=0`, `ack=0`, `c_start=0`, `c_data=0`, `c_rs=0`, `busy=0`.
  - Counter clears to 0; `last` resets to `NUM_REQ-1`.
  - Applies mid-operation; the interrupted command is not acknowledged and is not retried.

## Timing
- Request sampled in IDLE at edge t: `grant`/`busy` high and `c_start=1` in cycle t+1.
- `c_done` high in cycle d (in WAIT): DLY occupies cycles d+1 … d+DLY_CYCLES, `ack` is in cycle d+DLY_CYCLES+1, IDLE follows.
- Minimum spacing between `c_start` pulses is DLY_CYCLES+4 cycles: START, WAIT(≥1), DLY, ACK, IDLE.
- One IDLE cycle always separates consecutive grants.
- All outputs are registered or decoded from registered state; there is no combinational path from `req`/`c_done` to any output.

## Test plan
Bench settings: NUM_REQ=2, DLY_CYCLES=4, controller model asserting `c_done` 3 cycles after `c_start`.
- Reset then single request:
  - Stimulus: `req=01`, `cmd[8:0]=9'h038`.
  - Required: `c_start` one cycle after the request is sampled; `c_data=8'h38`, `c_rs=0`.
  - Required: `ack=01` exactly 5 cycles after `c_done`; `busy` falls the next cycle.
- Both request continuously:
  - Stimulus: `cmd0=9'h120`, `cmd1=9'h00C`.
  - Required: grants alternate 01,10,01,…; `c_data` alternates 8'h20, 8'h0C; `c_rs` alternates 1, 0.
- Requester 1 changes `cmd` and drops `req` right after grant:
  - Required: the original latched value stays on `c_data`, and `ack=10` still pulses once.
- Spurious `c_done`:
  - Stimulus: pulse `c_done` in IDLE and in the DLY cycle.
  - Required: state and counter are unaffected; `ack` timing is unchanged.
- Reset mid-operation:
  - Stimulus: `rst=0` for one edge during WAIT, then during DLY.
  - Required: all outputs are 0 the next cycle; no `ack`; the next service starts at source 0.
- Late request:
  - Stimulus: `req=10` rising during ACK of source 0.
  - Required: not granted until the following IDLE; its `grant` appears 2 cycles after the ACK cycle.
